switches_leds_ctrl: RTL and testbench

Board-level controller that sequences the 16-switch/16-LED datapath in four 4-bit groups. Each of the four push-buttons is synchronised and debounced, and its press cycles its group through SHOW → OFF → BLINK → SHOW. LED outputs are registered switch values masked per group state. It replaces the purely combinational hold-to-blank behaviour with latched, per-group modes.

---
 rtl/switches_leds_ctrl.sv | 113 +++++++++++
 tb/tb_switches_leds_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/switches_leds_ctrl.sv
// Four-group LED controller: each debounced push-button cycles its 4-LED group
// through SHOW -> OFF -> BLINK -> SHOW; LEDs are registered, masked switch values.
module switches_leds_ctrl #(
  parameter int DEBOUNCE_CYCLES = 10_000_000,
  parameter int BLINK_CYCLES    = 25_000_000
) (
  input  logic        clk_pi,
  input  logic        rst_pi,
  input  logic [15:0] switch_pi,
  input  logic [3:0]  boton_pi,
  output logic [15:0] led_po,
  output logic [7:0]  estado_po,
  output logic        fase_po
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  localparam logic [1:0] ST_SHOW  = 2'b00;
  localparam logic [1:0] ST_OFF   = 2'b01;
  localparam logic [1:0] ST_BLINK = 2'b10;

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    stable_prev_q, stable_prev_d;
  logic [3:0]    press;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [1:0]    state_q [4];
  logic [1:0]    state_d [4];
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          fase_q, fase_d;
  logic [15:0]   led_q, led_d;

  always_comb begin
    sync1_d       = boton_pi;
    sync2_d       = sync1_q;
    stable_prev_d = stable_q;
    press         = stable_q & ~stable_prev_q;
    stable_d      = stable_q;
    led_d         = '0;

    for (int g = 0; g < 4; g++) begin
      // Any agreement with the debounced level restarts the qualification window
      deb_cnt_d[g] = '0;
      if (sync2_q[g] != stable_q[g]) begin
        if (deb_cnt_q[g] == DEB_LAST) begin
          stable_d[g] = sync2_q[g];
        end else begin
          deb_cnt_d[g] = deb_cnt_q[g] + 1'b1;
        end
      end

      case (state_q[g])
        ST_SHOW:  state_d[g] = press[g] ? ST_OFF   : ST_SHOW;
        ST_OFF:   state_d[g] = press[g] ? ST_BLINK : ST_OFF;
        ST_BLINK: state_d[g] = press[g] ? ST_SHOW  : ST_BLINK;
        default:  state_d[g] = ST_SHOW;
      endcase

      case (state_q[g])
        ST_SHOW:  led_d[4*g +: 4] = switch_pi[4*g +: 4];
        ST_BLINK: led_d[4*g +: 4] = switch_pi[4*g +: 4] & {4{fase_q}};
        default:  led_d[4*g +: 4] = 4'h0;
      endcase
    end

    // Shared free-running blink timebase, never restarted by mode changes
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      fase_d      = ~fase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      fase_d      = fase_q;
    end
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      blink_cnt_q   <= '0;
      fase_q        <= 1'b0;
      led_q         <= '0;
      for (int g = 0; g < 4; g++) begin
        deb_cnt_q[g] <= '0;
        state_q[g]   <= ST_SHOW;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      blink_cnt_q   <= blink_cnt_d;
      fase_q        <= fase_d;
      led_q         <= led_d;
      for (int g = 0; g < 4; g++) begin
        deb_cnt_q[g] <= deb_cnt_d[g];
        state_q[g]   <= state_d[g];
      end
    end
  end

  assign led_po    = led_q;
  assign estado_po = {state_q[3], state_q[2], state_q[1], state_q[0]};
  assign fase_po   = fase_q;

endmodule

// File: tb/tb_switches_leds_ctrl.sv
// Scoreboard bench for switches_leds_ctrl: a press-counting reference model queues
// the expected outputs for every edge and a monitor compares them after each edge.
module tb_switches_leds_ctrl;

  localparam int N = 4;
  localparam int B = 8;

  typedef struct packed {
    logic [15:0] led;
    logic [7:0]  estado;
    logic        fase;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [3:0]  btn;
  logic [15:0] led;
  logic [7:0]  estado;
  logic        fase;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  exp_t exp_q[$];

  // Reference model: presses per group (mode = presses mod 3), edges since reset
  logic [3:0] hist [2];
  int         run [4];
  logic [3:0] level;
  logic [3:0] pending;
  int         presses [4];
  int         edges;

  switches_leds_ctrl #(.DEBOUNCE_CYCLES(N), .BLINK_CYCLES(B)) dut (
    .clk_pi(clk), .rst_pi(rst), .switch_pi(sw), .boton_pi(btn),
    .led_po(led), .estado_po(estado), .fase_po(fase)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    exp_t e;
    int   st;
    logic ph;
    logic s2;
    e = '0;
    if (rst) begin
      hist[0] = '0;
      hist[1] = '0;
      level   = '0;
      pending = '0;
      edges   = 0;
      for (int g = 0; g < 4; g++) begin
        run[g]     = 0;
        presses[g] = 0;
      end
    end else begin
      ph = ((edges / B) % 2) == 1;
      for (int g = 0; g < 4; g++) begin
        st = presses[g] % 3;
        for (int b = 0; b < 4; b++) begin
          if (st == 0)      e.led[4*g+b] = sw[4*g+b];
          else if (st == 2) e.led[4*g+b] = sw[4*g+b] & ph;
          else              e.led[4*g+b] = 1'b0;
        end
      end
      for (int g = 0; g < 4; g++) begin
        if (pending[g]) begin
          presses[g] = presses[g] + 1;
          pending[g] = 1'b0;
        end
        s2 = hist[1][g];
        if (s2 != level[g]) begin
          run[g] = run[g] + 1;
          if (run[g] == N) begin
            level[g] = s2;
            run[g]   = 0;
            if (s2) pending[g] = 1'b1;
          end
        end else begin
          run[g] = 0;
        end
      end
      hist[1] = hist[0];
      hist[0] = btn;
      edges   = edges + 1;
      for (int g = 0; g < 4; g++) e.estado[2*g +: 2] = 2'(presses[g] % 3);
      e.fase = ((edges / B) % 2) == 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic r, input logic [15:0] s, input logic [3:0] b,
                                input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = r;
      sw  = s;
      btn = b;
      model_step();
    end
  endtask

  task automatic check_output(input exp_t e);
    checks = checks + 3;
    if (led !== e.led) begin
      errors = errors + 1;
      $display("[TB] FAIL led cycle %0d got %h expected %h", cycle, led, e.led);
    end
    if (estado !== e.estado) begin
      errors = errors + 1;
      $display("[TB] FAIL estado cycle %0d got %h expected %h", cycle, estado, e.estado);
    end
    if (fase !== e.fase) begin
      errors = errors + 1;
      $display("[TB] FAIL fase cycle %0d got %b expected %b", cycle, fase, e.fase);
    end
  endtask

  // Monitor: one expected entry per edge, compared just after that edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle = cycle + 1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    logic [15:0] rs;
    logic [3:0]  rb;
    rst = 1'b1;
    sw  = 16'hFFFF;
    btn = 4'h0;

    $display("[TB] reset and SHOW");
    apply_stimulus(1'b1, 16'hFFFF, 4'h0, 3);
    apply_stimulus(1'b0, 16'hFFFF, 4'h0, 3);

    $display("[TB] clean press on group 1");
    apply_stimulus(1'b0, 16'hFFFF, 4'b0010, 12);
    apply_stimulus(1'b0, 16'hFFFF, 4'b0000, 8);

    $display("[TB] short pulse and bounce on group 0");
    apply_stimulus(1'b0, 16'hFFFF, 4'b0001, 3);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 16'hFFFF, {3'b000, 1'(i % 2)}, 1);
    apply_stimulus(1'b0, 16'hFFFF, 4'b0000, 8);

    $display("[TB] three presses on group 2 with blinking");
    for (int p = 0; p < 3; p++) begin
      apply_stimulus(1'b0, 16'hFFFF, 4'b0100, 8);
      apply_stimulus(1'b0, 16'hFFFF, 4'b0000, (p == 1) ? 30 : 8);
    end

    $display("[TB] simultaneous presses on all groups");
    apply_stimulus(1'b0, 16'hA5C3, 4'b1111, 8);
    apply_stimulus(1'b0, 16'hA5C3, 4'b0000, 8);
    apply_stimulus(1'b0, 16'hFFFF, 4'b1111, 8);
    apply_stimulus(1'b0, 16'hFFFF, 4'b0000, 13);

    $display("[TB] reset mid-debounce and mid-blink with a held button");
    apply_stimulus(1'b0, 16'hFFFF, 4'b1000, 3);
    apply_stimulus(1'b1, 16'hFFFF, 4'b1000, 2);
    apply_stimulus(1'b0, 16'hFFFF, 4'b1000, 12);
    apply_stimulus(1'b0, 16'hFFFF, 4'b0000, 8);

    $display("[TB] randomized button and switch activity");
    rs = 16'h0F0F;
    for (int seg = 0; seg < 50; seg++) begin
      rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rs = 16'($urandom);
      if ($urandom_range(0, 24) == 0) apply_stimulus(1'b1, rs, rb, 2);
      apply_stimulus(1'b0, rs, rb, $urandom_range(1, 12));
    end
    apply_stimulus(1'b0, rs, 4'h0, 4);

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
